// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/opcode and result/flag bundle for the registered ALU
//
// Purpose: groups the ALU operand inputs and registered result/flag outputs.
// Ports (signals):
//   a, b    WIDTH  operands A and B
//   opcode  3      operation select
//   out     WIDTH  registered result
//   cout    1      registered carry/borrow/shift-out of the current result
//   c_flag  1      sticky carry flag (arithmetic/shift ops only)
//   z_flag  1      registered zero flag
// Modports: master drives operands and observes results; slave is the ALU.
interface alu_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             c_flag;
  logic             z_flag;

  modport master (
    output a, b, opcode,
    input  out, cout, c_flag, z_flag
  );

  modport slave (
    input  a, b, opcode,
    output out, cout, c_flag, z_flag
  );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - registered 8-bit arithmetic/logic unit with carry and zero flags
//
// Purpose: computes add/sub/and/or/xor/compare/shift-left of the operands and
//   registers the result and flags on the rising clock edge (1-cycle latency).
// Ports:
//   clk     in   1      single clock, rising edge
//   rst     in   1      asynchronous active-high reset
//   bus     slave       alu_if: a, b, opcode in; out, cout, c_flag, z_flag out
module alu #(
  parameter int WIDTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_GT   = 3'b101;
  localparam logic [2:0] OP_SHLA = 3'b110;
  localparam logic [2:0] OP_SHLB = 3'b111;

  // One bit wider than the operands: the top bit is the carry, borrow or
  // shifted-out bit, depending on the operation.
  logic [WIDTH:0] res;
  logic           upd_c;

  always_comb begin
    res   = '0;
    upd_c = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        res   = {1'b0, bus.a} + {1'b0, bus.b};
        upd_c = 1'b1;
      end
      OP_SUB: begin
        // The borrow lands in the top bit because the zero-extended
        // difference wraps exactly when a < b.
        res   = {1'b0, bus.a} - {1'b0, bus.b};
        upd_c = 1'b1;
      end
      OP_AND:  res = {1'b0, bus.a & bus.b};
      OP_OR:   res = {1'b0, bus.a | bus.b};
      OP_XOR:  res = {1'b0, bus.a ^ bus.b};
      OP_GT:   res[0] = (bus.a > bus.b);
      OP_SHLA: begin
        res   = {bus.a, 1'b0};
        upd_c = 1'b1;
      end
      OP_SHLB: begin
        res   = {bus.b, 1'b0};
        upd_c = 1'b1;
      end
      default: begin
        res   = '0;
        upd_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out    <= '0;
      bus.cout   <= 1'b0;
      bus.c_flag <= 1'b0;
      bus.z_flag <= 1'b1;
    end else begin
      bus.out    <= res[WIDTH-1:0];
      bus.cout   <= res[WIDTH];
      bus.z_flag <= (res[WIDTH-1:0] == '0);
      // Logic and compare ops leave the sticky carry untouched.
      if (upd_c) begin
        bus.c_flag <= res[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking randomized bench for the registered ALU
module tb_alu;

  logic clk;
  logic rst;

  alu_if #(.WIDTH(8)) bus ();

  alu #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // reference model state: only the sticky carry survives between ops
  bit m_c;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out"}, int'(bus.out), 0);
    check({tag, "_cout"}, int'(bus.cout), 0);
    check({tag, "_c"}, int'(bus.c_flag), 0);
    check({tag, "_z"}, int'(bus.z_flag), 1);
  endtask

  // Apply one operation, let one rising edge capture it, then compare
  // against plain-integer arithmetic for that opcode.
  task automatic do_op(input string tag, input int op, input int a, input int b);
    int e_out;
    int e_cout;
    @(negedge clk);
    bus.opcode = op[2:0];
    bus.a      = a[7:0];
    bus.b      = b[7:0];
    @(posedge clk);
    #1;
    e_cout = 0;
    case (op)
      0: begin e_out = (a + b) % 256; e_cout = (a + b > 255) ? 1 : 0; end
      1: begin e_out = (a - b + 256) % 256; e_cout = (a < b) ? 1 : 0; end
      2: e_out = a & b;
      3: e_out = a | b;
      4: e_out = a ^ b;
      5: e_out = (a > b) ? 1 : 0;
      6: begin e_out = (a * 2) % 256; e_cout = (a >= 128) ? 1 : 0; end
      default: begin e_out = (b * 2) % 256; e_cout = (b >= 128) ? 1 : 0; end
    endcase
    if (op == 0 || op == 1 || op == 6 || op == 7) m_c = (e_cout != 0);
    check({tag, "_out"}, int'(bus.out), e_out);
    check({tag, "_cout"}, int'(bus.cout), e_cout);
    check({tag, "_c"}, int'(bus.c_flag), int'(m_c));
    check({tag, "_z"}, int'(bus.z_flag), (e_out == 0) ? 1 : 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_c   = 1'b0;
    rst        = 1'b1;
    bus.a      = 8'h00;
    bus.b      = 8'h00;
    bus.opcode = 3'b000;

    // reset held across several edges with a nonzero op pending
    @(negedge clk);
    bus.a = 8'h12; bus.b = 8'h34;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst_hold");
    @(negedge clk);
    rst = 1'b0;

    // directed cases
    do_op("add_basic", 0, 8, 20);
    do_op("add_wrap", 0, 8'hFF, 8'h01);
    do_op("and_keepc", 2, 8'hFF, 8'hFF);
    do_op("and_mix", 2, 8'hE5, 8'hFE);
    do_op("or", 3, 8'h32, 8'hFF);
    do_op("xor", 4, 8'h32, 8'hCF);
    do_op("sub_basic", 1, 15, 5);
    do_op("sub_borrow", 1, 5, 15);
    do_op("gt_true", 5, 25, 10);
    do_op("gt_false", 5, 10, 25);
    do_op("gt_equal", 5, 77, 77);
    do_op("shla", 6, 8'h6D, 8'h00);
    do_op("shlb", 7, 8'h00, 8'h8E);
    do_op("sub_zero", 1, 8'h40, 8'h40);
    do_op("xor_keepc", 4, 8'hAA, 8'hAA);

    // asynchronous reset mid-operation, asserted between edges
    @(negedge clk);
    bus.opcode = 3'b000; bus.a = 8'hF0; bus.b = 8'h20;
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("rst_async");
    @(posedge clk);
    #1;
    check_reset_state("rst_mid");
    m_c = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_op("post_rst", 0, 8'hF0, 8'h20);

    // randomized operations
    for (int i = 0; i < 300; i++) begin
      do_op("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
